// File: rtl/tx_arb_pkg.sv
// Shared definitions for tx_packet_arbiter: FSM encoding, setting-bus register
// offsets and requester flag bit positions.
package tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_e;

    localparam logic [7:0] REG_CTRL    = 8'd0;
    localparam logic [7:0] REG_TIMEOUT = 8'd1;
    localparam logic [7:0] REG_ERR     = 8'd2;

    localparam int unsigned CTRL_MODE_BIT = 2;

    localparam int unsigned FLAG_SOP = 0;
    localparam int unsigned FLAG_EOP = 1;

endpackage

// File: rtl/tx_arb_watchdog.sv
// Saturating stall counter: counts while 'count' is high, zeroes on 'clear',
// and flags 'expire' on the cycle the count reaches a nonzero 'limit'.
module tx_arb_watchdog #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         count,
    input  logic         clear,
    input  logic [W-1:0] limit,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d, cnt_inc;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + W'(1);

    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (count) begin
            cnt_d  = cnt_inc;
            expire = (limit != '0) && (cnt_inc >= limit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tx_packet_arbiter.sv
// Two-port packet arbiter feeding tx_control; locks onto one requester per packet.
// Optional per-port packet counters enabled by macro TX_PACKET_ARBITER_STATS_EN.
module tx_packet_arbiter
    import tx_arb_pkg::*;
#(
    parameter logic [7:0]  SR_BASE   = 8'd136,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [31:0] rd0_dat_i,
    input  logic [31:0] rd1_dat_i,
    input  logic [3:0]  rd0_flags_i,
    input  logic [3:0]  rd1_flags_i,
    input  logic        rd0_ready_i,
    input  logic        rd1_ready_i,
    output logic        rd0_ready_o,
    output logic        rd1_ready_o,
    output logic [31:0] tx_dat_o,
    output logic [3:0]  tx_flags_o,
    output logic        tx_ready_o,
    input  logic        tx_ready_i,
    output logic [1:0]  grant,
    output logic        abort,
    output logic [31:0] status
);

    localparam logic [7:0] ADDR_CTRL    = SR_BASE + REG_CTRL;
    localparam logic [7:0] ADDR_TIMEOUT = SR_BASE + REG_TIMEOUT;
    localparam logic [7:0] ADDR_ERR     = SR_BASE + REG_ERR;

    arb_state_e           state_q, state_d;
    logic [1:0]           en_q, en_d;
    logic                 mode_q, mode_d;
    logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
    logic [1:0]           err_q, err_d, err_set, err_clr;
    logic                 last_q, last_d;

    logic elig0, elig1, xfer0, xfer1, done0, done1;
    logic lock, own_valid, wd_expire;
    logic [15:0] stats_w;
    logic unused_set_data;

    assign unused_set_data = ^set_data;

    assign elig0 = en_q[0] & rd0_ready_i;
    assign elig1 = en_q[1] & rd1_ready_i;
    assign xfer0 = rd0_ready_i & rd0_ready_o;
    assign xfer1 = rd1_ready_i & rd1_ready_o;
    assign done0 = xfer0 & rd0_flags_i[FLAG_EOP];
    assign done1 = xfer1 & rd1_flags_i[FLAG_EOP];

    assign lock      = (state_q == ST_LOCK0) || (state_q == ST_LOCK1);
    assign own_valid = (state_q == ST_LOCK1) ? rd1_ready_i : rd0_ready_i;

    tx_arb_watchdog #(.W(TIMEOUT_W)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .count  (lock & ~own_valid),
        .clear  (~lock | xfer0 | xfer1),
        .limit  (timeout_q),
        .expire (wd_expire)
    );

    // Enables are consulted only in IDLE, so disabling a locked port lets its packet finish.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (elig0 && elig1)  state_d = (mode_q || last_q) ? ST_LOCK0 : ST_LOCK1;
                else if (elig0)      state_d = ST_LOCK0;
                else if (elig1)      state_d = ST_LOCK1;
            end
            ST_LOCK0: begin
                if (done0)          state_d = ST_IDLE;
                else if (wd_expire) state_d = ST_ABORT;
            end
            ST_LOCK1: begin
                if (done1)          state_d = ST_IDLE;
                else if (wd_expire) state_d = ST_ABORT;
            end
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_dat_o    = '0;
        tx_flags_o  = '0;
        tx_ready_o  = 1'b0;
        rd0_ready_o = 1'b0;
        rd1_ready_o = 1'b0;
        grant       = 2'b00;
        abort       = 1'b0;
        unique case (state_q)
            ST_LOCK0: begin
                tx_dat_o    = rd0_dat_i;
                tx_flags_o  = rd0_flags_i;
                tx_ready_o  = rd0_ready_i;
                rd0_ready_o = tx_ready_i;
                grant       = 2'b01;
            end
            ST_LOCK1: begin
                tx_dat_o    = rd1_dat_i;
                tx_flags_o  = rd1_flags_i;
                tx_ready_o  = rd1_ready_i;
                rd1_ready_o = tx_ready_i;
                grant       = 2'b10;
            end
            ST_ABORT: abort = 1'b1;
            default: ;
        endcase
    end

    // Error set wins over a same-cycle write-1-to-clear.
    always_comb begin
        en_d      = en_q;
        mode_d    = mode_q;
        timeout_d = timeout_q;
        last_d    = last_q;
        err_clr   = '0;
        err_set   = '0;
        if (set_stb) begin
            if (set_addr == ADDR_CTRL) begin
                en_d   = set_data[1:0];
                mode_d = set_data[CTRL_MODE_BIT];
            end else if (set_addr == ADDR_TIMEOUT) begin
                timeout_d = set_data[TIMEOUT_W-1:0];
            end else if (set_addr == ADDR_ERR) begin
                err_clr = set_data[1:0];
            end
        end
        if (done0) last_d = 1'b0;
        if (done1) last_d = 1'b1;
        err_set[0] = (state_q == ST_LOCK0) && wd_expire;
        err_set[1] = (state_q == ST_LOCK1) && wd_expire;
        err_d = (err_q & ~err_clr) | err_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            en_q      <= 2'b11;
            mode_q    <= 1'b0;
            timeout_q <= '0;
            err_q     <= '0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            last_q    <= last_d;
        end
    end

`ifdef TX_PACKET_ARBITER_STATS_EN
    logic [7:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q + 8'(done0);
        cnt1_d = cnt1_q + 8'(done1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign stats_w = {cnt1_q, cnt0_q};
`else
    assign stats_w = '0;
`endif

    assign status = {stats_w, 9'd0, err_q, mode_q, en_q, state_q};

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Directed bench for tx_packet_arbiter: queue-driven requesters, a packet-level
// reference model compared every cycle, plus literal checks on key scenarios.
module tb_tx_packet_arbiter;
    import tx_arb_pkg::*;

    localparam logic [7:0] BASE = 8'd136;

    logic        clk, rst_n;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [31:0] rd0_dat_i, rd1_dat_i;
    logic [3:0]  rd0_flags_i, rd1_flags_i;
    logic        rd0_ready_i, rd1_ready_i, rd0_ready_o, rd1_ready_o;
    logic [31:0] tx_dat_o;
    logic [3:0]  tx_flags_o;
    logic        tx_ready_o, tx_ready_i;
    logic [1:0]  grant;
    logic        abort;
    logic [31:0] status;

    tx_packet_arbiter #(.SR_BASE(BASE), .TIMEOUT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .rd0_dat_i(rd0_dat_i), .rd1_dat_i(rd1_dat_i),
        .rd0_flags_i(rd0_flags_i), .rd1_flags_i(rd1_flags_i),
        .rd0_ready_i(rd0_ready_i), .rd1_ready_i(rd1_ready_i),
        .rd0_ready_o(rd0_ready_o), .rd1_ready_o(rd1_ready_o),
        .tx_dat_o(tx_dat_o), .tx_flags_o(tx_flags_o), .tx_ready_o(tx_ready_o),
        .tx_ready_i(tx_ready_i),
        .grant(grant), .abort(abort), .status(status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester queues hold {flags[3:0], data[31:0]}; outq logs {port, data} leaving tx.
    logic [35:0] q0[$];
    logic [35:0] q1[$];
    logic [32:0] outq[$];
    logic hold0 = 1'b0, hold1 = 1'b0;
    logic xfer_seen0 = 1'b0, xfer_seen1 = 1'b0;

    task automatic drive_inputs();
        logic [35:0] h0, h1;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        rd0_ready_i = (q0.size() > 0) && !hold0;
        rd1_ready_i = (q1.size() > 0) && !hold1;
        rd0_dat_i = h0[31:0];  rd0_flags_i = h0[35:32];
        rd1_dat_i = h1[31:0];  rd1_flags_i = h1[35:32];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (xfer_seen0 && q0.size() > 0) void'(q0.pop_front());
        if (xfer_seen1 && q1.size() > 0) void'(q1.pop_front());
        drive_inputs();
    endtask

    task automatic push_pkt(input int port, input logic [31:0] base, input int len);
        logic [3:0] f;
        for (int i = 0; i < len; i++) begin
            f = 4'b0000;
            f[FLAG_SOP] = (i == 0);
            f[FLAG_EOP] = (i == len - 1);
            f[3:2] = 2'(i);
            if (port == 0) q0.push_back({f, base + 32'(i)});
            else           q1.push_back({f, base + 32'(i)});
        end
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        set_stb = 1'b1; set_addr = addr; set_data = data;
        step();
        set_stb = 1'b0; set_addr = '0; set_data = '0;
    endtask

    task automatic wait_out(input int n, input int budget, input string name);
        int k = 0;
        while (outq.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(name, 36'(outq.size() >= n), 36'd1);
    endtask

    // Packet-level reference: owner -1 = none, 0/1 = port holding the lock.
    int          m_own = -1;
    bit          m_abort = 0, m_last = 1, m_mode = 0;
    bit [1:0]    m_en = 2'b11, m_err = 2'b00;
    int unsigned m_to = 0, m_stall = 0;
    bit [7:0]    m_cnt0 = 0, m_cnt1 = 0;

    always @(posedge clk or negedge rst_n) begin : model
        int          nxt_own;
        bit          nxt_abort, nxt_last, v, took, eop;
        bit [1:0]    nxt_err;
        int unsigned nxt_stall;
        if (!rst_n) begin
            m_own = -1; m_abort = 0; m_last = 1; m_mode = 0; m_en = 2'b11;
            m_err = 0; m_to = 0; m_stall = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            nxt_own = m_own; nxt_abort = 0; nxt_last = m_last;
            nxt_err = m_err; nxt_stall = m_stall;
            if (set_stb && set_addr == BASE + 8'd2) nxt_err = nxt_err & ~set_data[1:0];
            if (m_abort) begin
                nxt_own = -1;
            end else if (m_own < 0) begin
                if (m_en[0] && rd0_ready_i && m_en[1] && rd1_ready_i)
                    nxt_own = m_mode ? 0 : 1 - int'(m_last);
                else if (m_en[0] && rd0_ready_i) nxt_own = 0;
                else if (m_en[1] && rd1_ready_i) nxt_own = 1;
            end else begin
                v    = (m_own == 1) ? rd1_ready_i : rd0_ready_i;
                eop  = (m_own == 1) ? rd1_flags_i[1] : rd0_flags_i[1];
                took = v && tx_ready_i;
                if (took) begin
                    nxt_stall = 0;
                    if (eop) begin
                        nxt_own = -1;
                        nxt_last = (m_own == 1);
                        if (m_own == 1) m_cnt1++; else m_cnt0++;
                    end
                end else if (!v) begin
                    if (nxt_stall < 65535) nxt_stall++;
                    if (m_to != 0 && nxt_stall >= m_to) begin
                        nxt_own = -1; nxt_abort = 1; nxt_err[m_own] = 1'b1;
                    end
                end
            end
            if (nxt_own < 0) nxt_stall = 0;
            if (set_stb && set_addr == BASE) begin
                m_en = set_data[1:0]; m_mode = set_data[2];
            end
            if (set_stb && set_addr == BASE + 8'd1) m_to = set_data[15:0];
            m_own = nxt_own; m_abort = nxt_abort; m_last = nxt_last;
            m_err = nxt_err; m_stall = nxt_stall;
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] e_dat, e_stat;
        logic [3:0]  e_flg;
        logic        e_txr, e_r0, e_r1;
        logic [1:0]  e_gnt, st;
        logic [15:0] e_cnt;
        xfer_seen0 = rd0_ready_i & rd0_ready_o;
        xfer_seen1 = rd1_ready_i & rd1_ready_o;
        if (tx_ready_o && tx_ready_i) outq.push_back({grant[1], tx_dat_o});
        e_dat = '0; e_flg = '0; e_txr = 0; e_r0 = 0; e_r1 = 0; e_gnt = 2'b00;
        if (m_own == 0) begin
            e_dat = rd0_dat_i; e_flg = rd0_flags_i; e_txr = rd0_ready_i; e_r0 = tx_ready_i; e_gnt = 2'b01;
        end else if (m_own == 1) begin
            e_dat = rd1_dat_i; e_flg = rd1_flags_i; e_txr = rd1_ready_i; e_r1 = tx_ready_i; e_gnt = 2'b10;
        end
        st = m_abort ? 2'd3 : (m_own < 0 ? 2'd0 : (m_own == 0 ? 2'd1 : 2'd2));
`ifdef TX_PACKET_ARBITER_STATS_EN
        e_cnt = {m_cnt1, m_cnt0};
`else
        e_cnt = 16'd0;
`endif
        e_stat = {e_cnt, 9'd0, m_err, m_mode, m_en, st};
        chk("cyc_grant",  36'(grant),       36'(e_gnt));
        chk("cyc_abort",  36'(abort),       36'(m_abort));
        chk("cyc_txrdy",  36'(tx_ready_o),  36'(e_txr));
        chk("cyc_txdat",  36'(tx_dat_o),    36'(e_dat));
        chk("cyc_txflg",  36'(tx_flags_o),  36'(e_flg));
        chk("cyc_rd0rdy", 36'(rd0_ready_o), 36'(e_r0));
        chk("cyc_rd1rdy", 36'(rd1_ready_o), 36'(e_r1));
        chk("cyc_status", 36'(status),      36'(e_stat));
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [32:0] exp8 [8];
        int k;
        rst_n = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0; tx_ready_i = 1'b1;
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_status", 36'(status), 36'h0000_000C);
        chk("reset_grant",  36'(grant), 36'd0);
        rst_n = 1'b1;
        step(); step();

        // Single 4-word packet on port 0
        outq.delete();
        push_pkt(0, 32'hA0, 4);
        drive_inputs();
        @(negedge clk);
        chk("arb_latency_grant_idle", 36'(grant), 36'd0);
        step();
        @(negedge clk);
        chk("arb_latency_grant_lock0", 36'(grant), 36'd1);
        wait_out(4, 20, "p0_pkt_done");
        for (int i = 0; i < 4; i++) chk("p0_pkt_word", 36'(outq[i]), 36'({1'b0, 32'hA0 + 32'(i)}));
        step();
        chk("p0_back_idle", 36'(status[1:0]), 36'd0);

        // Round robin: last granted is port 0, so port 1 goes first
        outq.delete();
        push_pkt(1, 32'h20, 2); push_pkt(1, 32'h22, 2);
        push_pkt(0, 32'h10, 2); push_pkt(0, 32'h12, 2);
        drive_inputs();
        wait_out(8, 60, "rr_done");
        exp8 = '{{1'b1, 32'h20}, {1'b1, 32'h21}, {1'b0, 32'h10}, {1'b0, 32'h11},
                 {1'b1, 32'h22}, {1'b1, 32'h23}, {1'b0, 32'h12}, {1'b0, 32'h13}};
        for (int i = 0; i < 8; i++) chk("rr_order", 36'(outq[i]), 36'(exp8[i]));

        // Strict priority: port 0 drains first
        wr(BASE, 32'h7);
        outq.delete();
        push_pkt(1, 32'h40, 2); push_pkt(1, 32'h42, 2);
        push_pkt(0, 32'h30, 2); push_pkt(0, 32'h32, 2);
        drive_inputs();
        wait_out(8, 60, "strict_done");
        exp8 = '{{1'b0, 32'h30}, {1'b0, 32'h31}, {1'b0, 32'h32}, {1'b0, 32'h33},
                 {1'b1, 32'h40}, {1'b1, 32'h41}, {1'b1, 32'h42}, {1'b1, 32'h43}};
        for (int i = 0; i < 8; i++) chk("strict_order", 36'(outq[i]), 36'(exp8[i]));
        wr(BASE, 32'h3);

        // Backpressure from tx_control is not a stall
        wr(BASE + 8'd1, 32'd3);
        outq.delete();
        push_pkt(0, 32'h50, 4);
        drive_inputs();
        wait_out(2, 20, "bp_first_half");
        tx_ready_i = 1'b0;
        repeat (10) step();
        tx_ready_i = 1'b1;
        wait_out(4, 30, "bp_done");
        repeat (3) step();
        chk("bp_count", 36'(outq.size()), 36'd4);
        for (int i = 0; i < 4; i++) chk("bp_word", 36'(outq[i]), 36'({1'b0, 32'h50 + 32'(i)}));
        chk("bp_no_err", 36'(status[6:5]), 36'd0);

        // Stall timeout on port 1
        wr(BASE + 8'd1, 32'd5);
        outq.delete();
        push_pkt(1, 32'h60, 4);
        drive_inputs();
        wait_out(2, 20, "to_first_half");
        hold1 = 1'b1;
        drive_inputs();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!abort && k < 30);
        chk("to_abort_cycle", 36'(k), 36'd6);
        chk("to_err_set", 36'(status[6:5]), 36'd2);
        step();
        @(negedge clk);
        chk("to_abort_one_cycle", 36'(abort), 36'd0);
        wr(BASE + 8'd2, 32'd2);
        @(negedge clk);
        chk("to_err_clear", 36'(status[6:5]), 36'd0);
        q1.delete(); hold1 = 1'b0;
        step();

        // Disabling port 1 mid-packet
        wr(BASE + 8'd1, 32'd0);
        outq.delete();
        push_pkt(1, 32'h70, 4);
        drive_inputs();
        wait_out(1, 20, "dis_started");
        wr(BASE, 32'h1);
        wait_out(4, 20, "dis_pkt_done");
        push_pkt(1, 32'h80, 2); push_pkt(0, 32'h90, 2);
        drive_inputs();
        repeat (20) step();
        chk("dis_count", 36'(outq.size()), 36'd6);
        chk("dis_p0_w0", 36'(outq[4]), 36'({1'b0, 32'h90}));
        chk("dis_p0_w1", 36'(outq[5]), 36'({1'b0, 32'h91}));
        chk("dis_p1_pending", 36'(q1.size()), 36'd2);
        q1.delete();
        wr(BASE, 32'h3);

        // Reset in the middle of a port 0 packet
        outq.delete();
        push_pkt(0, 32'hB0, 4);
        drive_inputs();
        wait_out(1, 20, "rst_started");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_grant",  36'(grant), 36'd0);
        chk("rst_txrdy",  36'(tx_ready_o), 36'd0);
        chk("rst_rd0rdy", 36'(rd0_ready_o), 36'd0);
        chk("rst_txdat",  36'(tx_dat_o), 36'd0);
        chk("rst_abort",  36'(abort), 36'd0);
        q0.delete();
        drive_inputs();
        repeat (2) step();
        chk("rst_status", 36'(status), 36'h0000_000C);
        rst_n = 1'b1;
        repeat (3) step();

`ifdef TX_PACKET_ARBITER_STATS_EN
        outq.delete();
        push_pkt(0, 32'hC0, 1); push_pkt(0, 32'hC1, 1); push_pkt(0, 32'hC2, 1);
        drive_inputs();
        wait_out(3, 30, "stats_done");
        step();
        chk("stats_cnt0", 36'(status[23:16]), 36'd3);
        chk("stats_cnt1", 36'(status[31:24]), 36'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_packet_arbiter.md
TX_PACKET_ARBITER -- requirements
Module: tx_packet_arbiter

Interface
REQ-001 SHALL have parameter SR_BASE, default 8'd136, setting-bus base address of this block's registers.
REQ-002 SHALL have parameter TIMEOUT_W, default 16, width of the stall-timeout counter.
REQ-003 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have ports set_stb / set_addr / set_data  in  1/8/32  setting bus; write when set_stb high.
REQ-006 SHALL have ports rd0_dat_i / rd1_dat_i  in  32  requester data words.
REQ-007 SHALL have ports rd0_flags_i / rd1_flags_i  in  4  bit0 sop, bit1 eop, bits3:2 ignored.
REQ-008 SHALL have ports rd0_ready_i / rd1_ready_i  in  1  requester word valid.
REQ-009 SHALL have ports rd0_ready_o / rd1_ready_o  out  1  requester word accepted.
REQ-010 SHALL have ports tx_dat_o / tx_flags_o / tx_ready_o  out  32/4/1  word, flags, valid toward tx_control.
REQ-011 SHALL have port tx_ready_i  in  1  tx_control accepts word.
REQ-012 SHALL have ports grant  out  2  one-hot owner; abort  out  1  one-cycle abort pulse; status  out  32  readback.

Function
- Transfer on a port = ready_i & ready_o in the same cycle.
REQ-013 SHALL implement states IDLE, LOCK0, LOCK1, ABORT.
REQ-014 IDLE: eligible port = enabled (CTRL.en[n]) and rdN_ready_i high; SHALL move to LOCKn next cycle; no words pass in IDLE (1-cycle arbitration latency).
REQ-015 Both eligible in IDLE: CTRL.mode=0 round-robin, winner = port not granted last; mode=1 strict, port 0 wins.
REQ-016 LOCKn: tx_dat_o/tx_flags_o/tx_ready_o SHALL be combinational copies of port n; rdN_ready_o = tx_ready_i; other port's ready_o = 0.
REQ-017 LOCKn: transfer with eop=1 SHALL return to IDLE next cycle and record n as last-granted.
REQ-018 Clearing CTRL.en[n] while in LOCKn SHALL NOT cut the packet; takes effect at next IDLE.
REQ-019 LOCKn: stall counter SHALL count cycles with rdN_ready_i=0, clear on any port-n transfer; reaching TIMEOUT register value (nonzero) SHALL go to ABORT; TIMEOUT=0 disables.
REQ-020 ABORT: SHALL pulse abort for exactly one cycle, set sticky err[n], return to IDLE; all ready_o low.
REQ-021 Stall counter SHALL saturate, never wrap.
REQ-022 Registers: SR_BASE+0 CTRL {[1:0] en, [2] mode}; SR_BASE+1 TIMEOUT[TIMEOUT_W-1:0]; SR_BASE+2 write-1-to-clear err[1:0]; other addresses ignored.
REQ-023 status SHALL be {counters or 0, err[1:0], mode, en[1:0], state[1:0]} in low bits per REQ-030.
REQ-024 grant SHALL equal 2'b01 in LOCK0, 2'b10 in LOCK1, 2'b00 otherwise.
REQ-025 Same-cycle err clear and err set SHALL leave err set.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, en=2'b11, mode=0, TIMEOUT=0, err=0, last-granted=1 (port 0 first), counters 0.
REQ-027 During reset all ready_o, tx_ready_o, abort, grant SHALL be 0; tx_dat_o 0.
REQ-028 Reset mid-packet SHALL drop the lock with no abort pulse.

Configuration
REQ-029 Macro TX_PACKET_ARBITER_STATS_EN SHALL gate per-port 8-bit wrapping packet counters (increment on eop transfer).
REQ-030 With macro: status[31:16] = {cnt1, cnt0}; without: status[31:16]=0 and no counter flops.

Structure
REQ-031 State encodings, register offsets and flag bit indices SHALL live in shared package tx_arb_pkg.
REQ-032 Stall counter SHALL be sub-module tx_arb_watchdog (count, clear, limit, expire).

Verification
REQ-033 Port 0 sends 4-word packet, port 1 idle -> grant=01 one cycle after valid, 4 words out in order, IDLE after eop.
REQ-034 Both ports valid continuously, mode=0 -> packets alternate 0,1,0,1; mode=1 -> port 0 only.
REQ-035 tx_ready_i low 10 cycles mid-packet -> no word lost or duplicated, no timeout counting.
REQ-036 TIMEOUT=5, port 1 drops valid mid-packet -> abort pulse on 6th idle cycle, err=2'b10, write 2 to SR_BASE+2 clears.
REQ-037 CTRL.en=01 written mid port-1 packet -> packet completes, then port 1 never granted.
REQ-038 rst_n asserted in LOCK0 -> outputs 0 same cycle, no abort; with stats macro three packets -> cnt0=3.
